// File: rtl/meter_peak_hold.sv
// Per-address decaying peak meter with sticky clip flag and host read with clear-on-read.
// One RAM holds {clip, magnitude}; a cleared-flag vector makes entries read 0 without RAM init.
module meter_peak_hold #(
    parameter int                    DATA_WIDTH  = 36,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DECAY_SHIFT = 10,
    parameter logic [DATA_WIDTH-2:0] CLIP_LEVEL  = 35'h7_FFFF_FFF0
) (
    input  logic                  dsp_clk,
    input  logic                  reset_n,
    input  logic                  in_en,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_clear,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);
    localparam int MW    = DATA_WIDTH - 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // reset: asynchronous assertion, release synchronised to dsp_clk
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // magnitude; the most-negative sample saturates to all-ones
    logic [DATA_WIDTH-1:0] abs_full;
    logic [MW-1:0]         in_mag;

    always_comb begin
        abs_full = in_data[DATA_WIDTH-1] ? (~in_data + DATA_WIDTH'(1)) : in_data;
        in_mag   = abs_full[DATA_WIDTH-1] ? '1 : abs_full[MW-1:0];
    end

    // storage
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] qa;
    logic [DATA_WIDTH-1:0] qb;
    logic [DEPTH-1:0]      cleared;
    logic [DEPTH-1:0]      cleared_nxt;

    // update pipeline state
    logic [2:1]            upd_vld;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic [MW-1:0]         s1_mag;
    logic [MW-1:0]         s2_mag;
    logic [DATA_WIDTH-1:0] s1_old;
    logic [DATA_WIDTH-1:0] s2_old;
    logic [DATA_WIDTH-1:0] s2_word;

    // last completed write, covers a RAM read issued on the same edge as that write
    logic                  wh_vld;
    logic [ADDR_WIDTH-1:0] wh_addr;
    logic [DATA_WIDTH-1:0] wh_word;

    // read pipeline state
    logic                  rd1_vld;
    logic                  rd1_clear;
    logic [ADDR_WIDTH-1:0] rd1_addr;
    logic [DATA_WIDTH-1:0] rd_cap;

    // S2 arithmetic
    logic [MW-1:0] old_mag;
    logic [MW-1:0] decayed;
    logic [MW-1:0] new_mag;
    logic          new_clip;

    always_comb begin
        old_mag  = s2_old[MW-1:0];
        decayed  = old_mag - (old_mag >> DECAY_SHIFT);
        new_mag  = (s2_mag > decayed) ? s2_mag : decayed;
        new_clip = s2_old[DATA_WIDTH-1] | (s2_mag >= CLIP_LEVEL);
        s2_word  = {new_clip, new_mag};
    end

    // S1 old value: a clear landing now wins, then in-flight S2, then flag, then held write, then RAM
    logic s1_rd_set;
    logic s1_s2_hit;
    logic s1_wh_hit;

    always_comb begin
        s1_rd_set = rd1_vld && rd1_clear && (rd1_addr == s1_addr);
        s1_s2_hit = upd_vld[2] && (s2_addr == s1_addr);
        s1_wh_hit = wh_vld && (wh_addr == s1_addr);
        if (s1_rd_set)             s1_old = '0;
        else if (s1_s2_hit)        s1_old = s2_word;
        else if (cleared[s1_addr]) s1_old = '0;
        else if (s1_wh_hit)        s1_old = wh_word;
        else                       s1_old = qa;
    end

    // read capture at T+1
    logic rd_s2_hit;
    logic rd_wh_hit;

    always_comb begin
        rd_s2_hit = upd_vld[2] && (s2_addr == rd1_addr);
        rd_wh_hit = wh_vld && (wh_addr == rd1_addr);
        if (rd_s2_hit)              rd_cap = s2_word;
        else if (cleared[rd1_addr]) rd_cap = '0;
        else if (rd_wh_hit)         rd_cap = wh_word;
        else                        rd_cap = qb;
    end

    // a read's set beats an S2 clear on the same address
    always_comb begin
        cleared_nxt = cleared;
        if (upd_vld[2])           cleared_nxt[s2_addr]  = 1'b0;
        if (rd1_vld && rd1_clear) cleared_nxt[rd1_addr] = 1'b1;
    end

    always_ff @(posedge dsp_clk) begin
        if (upd_vld[2]) mem[s2_addr] <= s2_word;
        if (in_en)      qa <= mem[in_addr];
        if (rd_en)      qb <= mem[rd_addr];
    end

    always_ff @(posedge dsp_clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_vld   <= '0;
            s1_addr   <= '0;
            s1_mag    <= '0;
            s2_addr   <= '0;
            s2_mag    <= '0;
            s2_old    <= '0;
            wh_vld    <= 1'b0;
            wh_addr   <= '0;
            wh_word   <= '0;
            rd1_vld   <= 1'b0;
            rd1_clear <= 1'b0;
            rd1_addr  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            cleared   <= '1;
        end else begin
            upd_vld <= {upd_vld[1], in_en};
            if (in_en) begin
                s1_addr <= in_addr;
                s1_mag  <= in_mag;
            end
            if (upd_vld[1]) begin
                s2_addr <= s1_addr;
                s2_mag  <= s1_mag;
                s2_old  <= s1_old;
            end
            wh_vld <= upd_vld[2];
            if (upd_vld[2]) begin
                wh_addr <= s2_addr;
                wh_word <= s2_word;
            end
            rd1_vld <= rd_en;
            if (rd_en) begin
                rd1_addr  <= rd_addr;
                rd1_clear <= rd_clear;
            end
            rd_valid <= rd1_vld;
            if (rd1_vld) rd_data <= rd_cap;
            cleared <= cleared_nxt;
        end
    end

endmodule
